// File: rtl/poly_pkg.sv
// Shared types and constants for the Horner polynomial sequencer.
package poly_pkg;

   localparam int C_FP_DWIDTH = 32;

   typedef logic [C_FP_DWIDTH-1:0] float_t;

   typedef enum logic [2:0] {
      S_IDLE,
      S_MUL_ISSUE,
      S_MUL_WAIT,
      S_ADD_ISSUE,
      S_ADD_WAIT,
      S_OUTPUT
   } seq_state_t;

   localparam float_t C_FP_ZERO = 32'h0000_0000;
   localparam float_t C_FP_ONE  = 32'h3F80_0000;

   function automatic int max_int(input int a, input int b);
      return (a > b) ? a : b;
   endfunction

endpackage

// File: rtl/poly_coef_bank.sv
// Coefficient register file c[0..N]: synchronous write, combinational read.
module poly_coef_bank
   import poly_pkg::*;
#(
   parameter  int G_POLY_ORDER = 5,
   localparam int C_ADDR_W     = $clog2(G_POLY_ORDER + 1)
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                wr_en,
   input  logic [C_ADDR_W-1:0] wr_addr,
   input  float_t              wr_data,
   input  logic [C_ADDR_W-1:0] rd_addr,
   output float_t              rd_data
);

   localparam logic [C_ADDR_W-1:0] C_TOP_IDX = C_ADDR_W'(G_POLY_ORDER);

   float_t coef_q [G_POLY_ORDER+1];
   float_t coef_d [G_POLY_ORDER+1];

   // Apply a write only when the index lands inside the bank.
   always_comb begin
      coef_d = coef_q;
      if (wr_en && (wr_addr <= C_TOP_IDX)) begin
         coef_d[wr_addr] = wr_data;
      end
   end

   // Bank storage, cleared on reset.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         coef_q <= '{default: C_FP_ZERO};
      end else begin
         coef_q <= coef_d;
      end
   end

   assign rd_data = (rd_addr <= C_TOP_IDX) ? coef_q[rd_addr] : C_FP_ZERO;

endmodule

// File: rtl/poly_horner_sequencer.sv
// Horner-rule polynomial evaluator driving one shared FP multiplier and one
// shared FP adder. Values are opaque 32-bit words; no arithmetic happens here.
//
// state        | meaning
// S_IDLE       | waiting for a sample, coefficient writes allowed
// S_MUL_ISSUE  | one-cycle multiplier issue of acc * x
// S_MUL_WAIT   | waiting for the product
// S_ADD_ISSUE  | one-cycle adder issue of product + c[k]
// S_ADD_WAIT   | waiting for the sum; loop or finish
// S_OUTPUT     | result presented until downstream accepts
module poly_horner_sequencer
   import poly_pkg::*;
#(
   parameter int G_POLY_ORDER  = 5,
   parameter int G_MUL_LATENCY = 4,
   parameter int G_ADD_LATENCY = 5
) (
   input  logic                                clk,
   input  logic                                reset,
   input  logic                                enable,
   input  logic                                coef_wr_en,
   input  logic [$clog2(G_POLY_ORDER+1)-1:0]   coef_wr_addr,
   input  float_t                              coef_wr_data,
   input  float_t                              din,
   input  logic                                din_valid,
   output logic                                din_ready,
   output float_t                              dout,
   output logic                                dout_valid,
   input  logic                                dout_ready,
   output float_t                              mul_din1,
   output float_t                              mul_din2,
   output logic                                mul_din_valid,
   input  float_t                              mul_dout,
   input  logic                                mul_dout_valid,
   output float_t                              add_din1,
   output float_t                              add_din2,
   output logic                                add_din_valid,
   input  float_t                              add_dout,
   input  logic                                add_dout_valid,
   output logic                                busy,
   output logic                                seq_error
);

   localparam int C_ADDR_W  = $clog2(G_POLY_ORDER + 1);
   localparam int C_GUARD   = max_int(G_MUL_LATENCY, G_ADD_LATENCY);
   localparam int C_GUARD_W = $clog2(C_GUARD + 1);
   localparam logic [C_ADDR_W-1:0]  C_TOP_IDX  = C_ADDR_W'(G_POLY_ORDER);
   localparam logic [C_ADDR_W-1:0]  C_IDX_ONE  = C_ADDR_W'(1);
   localparam logic [C_GUARD_W-1:0] C_GUARD_LD = C_GUARD_W'(C_GUARD);
   localparam logic [C_GUARD_W-1:0] C_GUARD_ONE = C_GUARD_W'(1);

   seq_state_t            state_q, state_d;
   float_t                x_q, x_d, acc_q, acc_d, prod_q, prod_d, dout_q, dout_d;
   logic [C_ADDR_W-1:0]   k_q, k_d, rd_idx;
   logic [C_GUARD_W-1:0]  guard_q, guard_d;
   logic                  seq_error_q, seq_error_d;
   float_t                coef_rd, top_coef;
   logic                  idle, accept, coef_we, quiet, mul_ok, add_ok;

   assign idle    = (state_q == S_IDLE);
   // After an abort, hold off new samples until any in-flight unit result has
   // drained, so a stale result can never land in a fresh evaluation.
   assign din_ready = idle && enable && (guard_q == '0);
   assign accept  = din_ready && din_valid;
   assign coef_we = coef_wr_en && idle;
   assign quiet   = !enable || (guard_q != '0);
   assign mul_ok  = enable && mul_dout_valid && (state_q == S_MUL_WAIT);
   assign add_ok  = enable && add_dout_valid && (state_q == S_ADD_WAIT);
   assign rd_idx  = idle ? C_TOP_IDX : k_q;
   // A write to c[N] in the accepting cycle must reach acc directly.
   assign top_coef = (coef_we && (coef_wr_addr == C_TOP_IDX)) ? coef_wr_data : coef_rd;

   poly_coef_bank #(
      .G_POLY_ORDER (G_POLY_ORDER)
   ) u_coef_bank (
      .clk     (clk),
      .reset   (reset),
      .wr_en   (coef_we),
      .wr_addr (coef_wr_addr),
      .wr_data (coef_wr_data),
      .rd_addr (rd_idx),
      .rd_data (coef_rd)
   );

   // State and datapath registers.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q     <= S_IDLE;
         x_q         <= C_FP_ZERO;
         acc_q       <= C_FP_ZERO;
         prod_q      <= C_FP_ZERO;
         dout_q      <= C_FP_ZERO;
         k_q         <= '0;
         guard_q     <= '0;
         seq_error_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         x_q         <= x_d;
         acc_q       <= acc_d;
         prod_q      <= prod_d;
         dout_q      <= dout_d;
         k_q         <= k_d;
         guard_q     <= guard_d;
         seq_error_q <= seq_error_d;
      end
   end

   // Next-state logic; enable low forces a return to idle from anywhere.
   always_comb begin
      state_d = state_q;
      if (!enable) begin
         state_d = S_IDLE;
      end else begin
         case (state_q)
            S_IDLE:      if (accept) state_d = S_MUL_ISSUE;
            S_MUL_ISSUE: state_d = S_MUL_WAIT;
            S_MUL_WAIT:  if (mul_dout_valid) state_d = S_ADD_ISSUE;
            S_ADD_ISSUE: state_d = S_ADD_WAIT;
            S_ADD_WAIT:  if (add_dout_valid) state_d = (k_q == '0) ? S_OUTPUT : S_MUL_ISSUE;
            S_OUTPUT:    if (dout_ready) state_d = S_IDLE;
            default:     state_d = S_IDLE;
         endcase
      end
   end

   // Datapath updates, abort guard window and sticky sequencing error.
   always_comb begin
      x_d    = x_q;
      acc_d  = acc_q;
      prod_d = prod_q;
      dout_d = dout_q;
      k_d    = k_q;
      if (accept) begin
         x_d   = din;
         acc_d = top_coef;
         k_d   = C_TOP_IDX - C_IDX_ONE;
      end
      if (mul_ok) begin
         prod_d = mul_dout;
      end
      if (add_ok) begin
         acc_d = add_dout;
         if (k_q == '0) begin
            dout_d = add_dout;
         end else begin
            k_d = k_q - C_IDX_ONE;
         end
      end
      guard_d = guard_q;
      if (!enable) begin
         guard_d = C_GUARD_LD;
      end else if (guard_q != '0) begin
         guard_d = guard_q - C_GUARD_ONE;
      end
      seq_error_d = seq_error_q;
      if (!quiet && ((mul_dout_valid && (state_q != S_MUL_WAIT)) ||
                     (add_dout_valid && (state_q != S_ADD_WAIT)))) begin
         seq_error_d = 1'b1;
      end
   end

   // Unit operand muxing and issue pulses.
   always_comb begin
      mul_din1      = C_FP_ZERO;
      mul_din2      = C_FP_ZERO;
      mul_din_valid = 1'b0;
      add_din1      = C_FP_ZERO;
      add_din2      = C_FP_ZERO;
      add_din_valid = 1'b0;
      if (enable) begin
         case (state_q)
            S_MUL_ISSUE: begin
               mul_din1      = acc_q;
               mul_din2      = x_q;
               mul_din_valid = 1'b1;
            end
            S_ADD_ISSUE: begin
               add_din1      = prod_q;
               add_din2      = coef_rd;
               add_din_valid = 1'b1;
            end
            default: ;
         endcase
      end
   end

   assign dout       = dout_q;
   assign dout_valid = (state_q == S_OUTPUT);
   assign busy       = !idle;
   assign seq_error  = seq_error_q;

endmodule
